// File: rtl/param_seq_arith_unit.sv
// rtl/param_seq_arith_unit.sv - lane-loaded A/B registers with add, subtract and shift-add MAC into B
// Optional macro SAT_ARITH_EN: ADD/SUB/MAC results saturate instead of wrapping.
module param_seq_arith_unit #(
   parameter  int W     = 16,
   parameter  int IN_W  = 8,
   localparam int LANES = W / IN_W,
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [2:0]      op_code,
   input  logic [LW-1:0]   op_lane,
   input  logic            signed_mode,
   input  logic [IN_W-1:0] operand,
   input  logic            err_clr,
   input  logic            rd_reg,
   input  logic [LW-1:0]   rd_lane,
   output logic [IN_W-1:0] rd_data,
   output logic            busy,
   output logic            done,
   output logic            carry,
   output logic            neg,
   output logic            err
);
   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [2:0] OP_NOP = 3'd0, OP_LDA = 3'd1, OP_LDB = 3'd2, OP_ADD = 3'd3,
                          OP_SUB = 3'd4, OP_MAC = 3'd5, OP_CLR = 3'd6;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   state_t          state;
   logic [W-1:0]    a, b;
   logic [IN_W-1:0] opl;
   logic [CW-1:0]   cnt;
   logic            mode_l;
   logic            carry_r, neg_r, err_r, done_r;

   logic [W-1:0]    ext, term, addend, sum, alu_b, mac_b;
   logic            cin, cout, ovf, mode_eff, flag, step_flag, last, lane_ok, accept, err_set;
`ifdef SAT_ARITH_EN
   localparam int PW = W + IN_W + 1;
   localparam logic [W-1:0] U_MAX = '1;
   localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
   logic [W-1:0]         b0;
   logic signed [PW-1:0] true_v;
`endif

   assign op_ready = (state == IDLE);
   assign busy     = (state == RUN);
   assign done     = done_r;
   assign carry    = carry_r;
   assign neg      = neg_r;
   assign err      = err_r;
   assign accept   = op_valid & op_ready;

   always_comb begin
      rd_data = '0;
      lane_ok = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (rd_lane == LW'(i)) rd_data = rd_reg ? b[i*IN_W +: IN_W] : a[i*IN_W +: IN_W];
         if (op_lane == LW'(i)) lane_ok = 1'b1;
      end
   end

   // One adder serves ADD/SUB in IDLE and the per-bit MAC step in RUN.
   always_comb begin
      ext  = signed_mode ? W'($signed(operand)) : W'(operand);
      term = a << cnt;
      last = (cnt == CW'(IN_W - 1));
      if (state == RUN) begin
         mode_eff = mode_l;
         cin      = mode_l & last;
         addend   = cin ? ~term : term;
      end else begin
         mode_eff = signed_mode;
         cin      = (op_code == OP_SUB);
         addend   = cin ? ~ext : ext;
      end
      {cout, sum} = {1'b0, b} + {1'b0, addend} + {{W{1'b0}}, cin};
      ovf       = (b[W-1] == addend[W-1]) && (sum[W-1] != b[W-1]);
      flag      = mode_eff ? ovf : cout;
      step_flag = opl[cnt] & flag;
      alu_b     = sum;
      mac_b     = opl[cnt] ? sum : b;
`ifdef SAT_ARITH_EN
      true_v = PW'($signed(b0)) + PW'($signed(a)) * PW'($signed(opl));
      if (mode_eff ? ovf : (cin ? ~cout : cout))
         alu_b = mode_eff ? (b[W-1] ? S_MIN : S_MAX) : (cin ? '0 : U_MAX);
      if (last && (carry_r | step_flag))
         mac_b = !mode_l ? U_MAX : (true_v[PW-1] ? S_MIN : S_MAX);
`endif
   end

   assign err_set = (accept && op_code == 3'd7)
                 || (accept && (op_code == OP_LDA || op_code == OP_LDB) && !lane_ok)
                 || (state == RUN && signed_mode != mode_l);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a       <= '0;
         b       <= '0;
         opl     <= '0;
         cnt     <= '0;
         mode_l  <= 1'b0;
         carry_r <= 1'b0;
         neg_r   <= 1'b0;
         err_r   <= 1'b0;
         done_r  <= 1'b0;
`ifdef SAT_ARITH_EN
         b0      <= '0;
`endif
      end else begin
         done_r <= 1'b0;
         if (err_set)      err_r <= 1'b1;
         else if (err_clr) err_r <= 1'b0;
         case (state)
            IDLE: if (op_valid) begin
               case (op_code)
                  OP_NOP: ;
                  OP_LDA, OP_LDB: begin
                     done_r <= 1'b1;
                     for (int i = 0; i < LANES; i++) begin
                        if (op_lane == LW'(i)) begin
                           if (op_code == OP_LDA) a[i*IN_W +: IN_W] <= operand;
                           else                   b[i*IN_W +: IN_W] <= operand;
                        end
                     end
                  end
                  OP_ADD, OP_SUB: begin
                     done_r  <= 1'b1;
                     b       <= alu_b;
                     carry_r <= flag;
                     neg_r   <= alu_b[W-1] & signed_mode;
                  end
                  OP_MAC: begin
                     state   <= RUN;
                     opl     <= operand;
                     mode_l  <= signed_mode;
                     cnt     <= '0;
                     carry_r <= 1'b0;
`ifdef SAT_ARITH_EN
                     b0      <= b;
`endif
                  end
                  OP_CLR: begin
                     done_r  <= 1'b1;
                     a       <= '0;
                     b       <= '0;
                     carry_r <= 1'b0;
                     neg_r   <= 1'b0;
                  end
                  default: done_r <= 1'b1;
               endcase
            end
            RUN: begin
               b       <= mac_b;
               carry_r <= carry_r | step_flag;
               cnt     <= cnt + CW'(1);
               if (last) begin
                  state  <= IDLE;
                  done_r <= 1'b1;
                  neg_r  <= mac_b[W-1] & mode_l;
               end
            end
         endcase
      end
   end
endmodule
